// File: rtl/bus_accumulator_bank.sv
// Bank of NUM_REGS accumulators sharing one tri-state data bus. Each register can be
// loaded from the bus (or from another register via the bus), modified in place by a
// single-cycle op, or driven back onto the bus. Flags track the last written result.
module bus_accumulator_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned SEL_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             load_n,
  input  logic [2:0]       op,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic             out_en,
  output logic [WIDTH-1:0] acc_out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c
);

  typedef enum logic [2:0] {
    OpNop = 3'b000,
    OpClr = 3'b001,
    OpInc = 3'b010,
    OpDec = 3'b011,
    OpShl = 3'b100,
    OpShr = 3'b101,
    OpRol = 3'b110,
    OpNot = 3'b111
  } op_e;

  // One extra bit so the range check also works when NUM_REGS is a power of two.
  localparam logic [SEL_W:0] NumRegsCmp = (SEL_W + 1)'(NUM_REGS);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             c_q, c_d;

  logic             rd_ok, wr_ok;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] op_res;
  logic             op_c;
  logic [WIDTH-1:0] ld_data;

  assign rd_ok = {1'b0, rd_sel} < NumRegsCmp;
  assign wr_ok = {1'b0, wr_sel} < NumRegsCmp;

  // Read port: out-of-range selects read as zero.
  always_comb begin
    rd_data = '0;
    cur     = '0;
    if (rd_ok) rd_data = regs_q[rd_sel];
    if (wr_ok) cur = regs_q[wr_sel];
  end

  assign acc_out = rd_data;

  // Bus is released whenever reset is asserted, independent of out_en.
  assign bus = (out_en && rst_n) ? rd_data : {WIDTH{1'bz}};

  // A register-to-register transfer takes the source straight from the read port,
  // which is the value being placed on the bus in that cycle.
  assign ld_data = out_en ? rd_data : bus;

  // In-place op unit: result and carry for the register selected by wr_sel.
  always_comb begin
    op_res = cur;
    op_c   = c_q;
    unique case (op_e'(op))
      OpNop: begin
        op_res = cur;
        op_c   = c_q;
      end
      OpClr: begin
        op_res = '0;
        op_c   = 1'b0;
      end
      OpInc: {op_c, op_res} = {1'b0, cur} + (WIDTH + 1)'(1);
      OpDec: {op_c, op_res} = {1'b0, cur} - (WIDTH + 1)'(1);
      OpShl: {op_c, op_res} = {cur, 1'b0};
      OpShr: {op_res, op_c} = {1'b0, cur};
      OpRol: begin
        op_res = {cur[WIDTH-2:0], cur[WIDTH-1]};
        op_c   = cur[WIDTH-1];
      end
      OpNot: begin
        op_res = ~cur;
        op_c   = 1'b0;
      end
      default: begin
        op_res = cur;
        op_c   = c_q;
      end
    endcase
  end

  // Next-state: load beats op; NOP with no load and out-of-range writes hold everything.
  always_comb begin
    regs_d = regs_q;
    z_d    = z_q;
    n_d    = n_q;
    c_d    = c_q;
    if (wr_ok) begin
      if (!load_n) begin
        regs_d[wr_sel] = ld_data;
        z_d            = (ld_data == '0);
        n_d            = ld_data[WIDTH-1];
      end else if (op_e'(op) != OpNop) begin
        regs_d[wr_sel] = op_res;
        z_d            = (op_res == '0);
        n_d            = op_res[WIDTH-1];
        c_d            = op_c;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      z_q <= 1'b1;
      n_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      z_q    <= z_d;
      n_q    <= n_d;
      c_q    <= c_d;
    end
  end

  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_c = c_q;

endmodule
